fb_write_scheduler: RTL and testbench
=====================================

# fb_write_scheduler

Write-side scheduler for the double-buffered tile frame buffer (32×24 tiles of 20×20 pixels, one 8-bit tile code per address). It shares the buffer's single write port between two drawing requesters using round-robin arbitration. It also runs a built-in clear engine that fills the freshly swapped back buffer with one colour at frame start. It sits directly upstream of the frame-buffer write port (`wr_addr`/`wr_data`/`wr_en`) and is clocked by the same `clk` as the buffer swap logic.

## Interface
Parameters:
- `ADDR_W`, default 10: write address width.
- `DATA_W`, default 8: tile data width.
- `TILES`, default 768: number of valid tile addresses (32×24). Addresses ≥ `TILES` are out of range.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `frame_start`, in, 1: one-cycle pulse on the cycle the buffers swap, i.e. scan position h=0, v=0.
- `clear_req`, in, 1: single-cycle request to clear the back buffer at the next `frame_start`.
- `clear_color`, in, `DATA_W`: fill value, sampled at clear start.
- `req0_valid`, in, 1: requester 0 has a write pending.
- `req0_addr`, in, `ADDR_W`: requester 0 write address.
- `req0_data`, in, `DATA_W`: requester 0 write data.
- `req0_ready`, out, 1: requester 0 write accepted this cycle.
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `wr_addr`, out, `ADDR_W`: registered write address to the frame buffer.
- `wr_data`, out, `DATA_W`: registered write data.
- `wr_en`, out, 1: registered write strobe.
- `busy`, out, 1: clear engine active.
- `clear_done`, out, 1: one-cycle pulse after the final clear write is issued.
- `addr_err`, out, 1: one-cycle pulse when an accepted request had an address ≥ `TILES`.

## Operation
- **State machine:** two states, IDLE and CLEAR. Reset state is IDLE.
  - IDLE → CLEAR: on an edge where `frame_start`=1 and `clear_pending`=1. At that edge, counter ← 0, latched colour ← `clear_color`, `clear_pending` ← 0.
  - CLEAR → IDLE: on the edge that issues the write to address `TILES`−1.
- **Pending flag:** `clear_pending` is set by `clear_req`. If `clear_req` and `frame_start` are both high in IDLE, the clear starts at that same edge.
  - `clear_req` while already pending: no additional effect.
  - `clear_req` during CLEAR: sets pending, which serves the next frame.
- **CLEAR writes:** each edge issues one write (`wr_en`=1, `wr_addr`=count, `wr_data`=latched colour), then the counter increments. Count runs 0..`TILES`−1 with no wrap.
  - Both `req*_ready` are held at 0 throughout CLEAR.
- **`frame_start` during CLEAR:** restarts the counter at 0, re-latches `clear_color`, and consumes `clear_pending` if it is set. The new back buffer is cleared fully.
- **IDLE arbitration:** a handshake completes when `reqN_valid` && `reqN_ready`. `ready` is combinational.
  - If exactly one requester is valid, it is granted.
  - If both are valid, the one not granted last is granted. The last-grant pointer updates on every grant and resets to 1, so req0 wins the first contention.
  - At most one grant per cycle. `ready` for a non-valid requester is 0.
- **Accepted requests:** on the next edge, `wr_en`=1 and `wr_addr`/`wr_data` take the request values.
- **Out-of-range requests:** if `addr` ≥ `TILES`, the request is accepted (`ready`=1) but `wr_en` stays 0, and `addr_err` pulses on the next edge.
- **No grant:** in a cycle with no grant, `wr_en` ← 0 and `wr_addr`/`wr_data` hold their values.
- **Reset:** while `rst_n`=0, both readies are forced to 0. Reset mid-clear abandons the clear and clears the pending flag.

## Timing
- **Reset values:** `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `clear_done`=0, `addr_err`=0. Internally: state IDLE, pointer=1, `clear_pending`=0.
- **Request latency:** a handshake at edge E produces `wr_en`=1 from E until E+1 (one cycle of latency).
- **Swap boundary:** a handshake on the `frame_start` cycle lands in the new back buffer.
- **`busy`:** equals (state==CLEAR). It is high from edge T to edge T+`TILES`, where T is the starting `frame_start` edge.
- **Clear sequence:**
  - Clear write k is visible after edge T+1+k, for k = 0..`TILES`−1.
  - `clear_done` is high for the cycle after edge T+`TILES`.
  - `req*_ready` can first be 1 in the cycle after edge T+`TILES`.
- **Clear duration:** `TILES` (768) cycles, far shorter than one frame.

## Test plan
- **Reset:** assert `rst_n`=0 mid-activity, then release → all outputs match the reset values; no `wr_en` until the first handshake.
- **Single requester:** req0 writes addr 5, data 0x3C → `req0_ready`=1 that cycle; next cycle `wr_en`=1, `wr_addr`=5, `wr_data`=0x3C.
- **Contention:** both valid for 4 cycles (req0: addrs 0–3, req1: addrs 100–103) → grant order req0, req1, req0, req1; `wr_addr` sequence 0, 100, 1, 101.
- **Clear:** pulse `clear_req`, then `frame_start` with `clear_color`=0x07 → 768 consecutive writes of 0x07 to addrs 0..767; `busy` high for 768 cycles; `clear_done` single pulse; req1 (held valid) is stalled and then accepted the cycle after the clear finishes.
- **Boundaries:**
  - Second `frame_start` at clear count 400 → counter restarts at addr 0.
  - req0 at addr 800 → `ready`=1, no `wr_en`, `addr_err` pulses once.
  - `clear_req` coincident with `frame_start` → clear starts at that edge.

Source files
------------

// File: rtl/fb_write_scheduler.sv
// Write-port scheduler for the tile frame buffer: round-robin between two
// drawing requesters plus a back-buffer clear engine started at frame swap.
module fb_write_scheduler #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8,
   parameter int TILES  = 768
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_start,
   input  logic              clear_req,
   input  logic [DATA_W-1:0] clear_color,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_en,
   output logic              busy,
   output logic              clear_done,
   output logic              addr_err
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TILES - 1);

   state_t              state_q, state_d;
   logic                pend_q;
   logic                last_q;
   logic [ADDR_W-1:0]   cnt_q;
   logic [DATA_W-1:0]   color_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [DATA_W-1:0]   wr_data_q;
   logic                wr_en_q;
   logic                done_q;
   logic                err_q;

   logic                start;
   logic                g0, g1;
   logic [ADDR_W-1:0]   g_addr;
   logic [DATA_W-1:0]   g_data;

   // A swap in CLEAR always restarts; in IDLE it needs a pending request.
   assign start = frame_start &&
                  (state_q == CLEAR || pend_q || clear_req);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start) state_d = CLEAR;
         CLEAR: if (!frame_start && cnt_q == LAST) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // last_q = 1 means req1 was granted last, so req0 wins a tie.
   always_comb begin
      busy   = (state_q == CLEAR);
      g0     = rst_n && !busy && req0_valid && (!req1_valid || last_q);
      g1     = rst_n && !busy && req1_valid && (!req0_valid || !last_q);
      g_addr = g1 ? req1_addr : req0_addr;
      g_data = g1 ? req1_data : req0_data;
   end

   assign req0_ready = g0;
   assign req1_ready = g1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q    <= 1'b0;
         last_q    <= 1'b1;
         cnt_q     <= '0;
         color_q   <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         pend_q  <= (pend_q | clear_req) & ~frame_start;
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         if (state_q == IDLE) begin
            if (g0 || g1) begin
               last_q <= g1;
               if (32'(g_addr) < TILES) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= g_addr;
                  wr_data_q <= g_data;
               end else begin
                  err_q <= 1'b1;
               end
            end
         end else if (!frame_start) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt_q;
            wr_data_q <= color_q;
            cnt_q     <= cnt_q + ADDR_W'(1);
            if (cnt_q == LAST) done_q <= 1'b1;
         end
         if (start) begin
            cnt_q   <= '0;
            color_q <= clear_color;
         end
      end
   end

   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign wr_en      = wr_en_q;
   assign clear_done = done_q;
   assign addr_err   = err_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed self-checking bench for fb_write_scheduler.
module tb_fb_write_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       frame_start, clear_req;
   logic [7:0] clear_color;
   logic       req0_valid, req1_valid;
   logic [9:0] req0_addr, req1_addr;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic [9:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_en, busy, clear_done, addr_err;

   int tests = 0;
   int fails = 0;

   fb_write_scheduler dut (
      .clk(clk), .rst_n(rst_n),
      .frame_start(frame_start), .clear_req(clear_req),
      .clear_color(clear_color),
      .req0_valid(req0_valid), .req0_addr(req0_addr),
      .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr),
      .req1_data(req1_data), .req1_ready(req1_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
      .busy(busy), .clear_done(clear_done), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int bad, bc, dc, rc;
      logic [9:0] ea [4];
      logic       eg [4];
      ea = '{10'd0, 10'd100, 10'd1, 10'd101};
      eg = '{1'b1, 1'b0, 1'b1, 1'b0};

      rst_n = 0; frame_start = 0; clear_req = 0;
      clear_color = 0;
      req0_valid = 0; req0_addr = 0; req0_data = 0;
      req1_valid = 0; req1_addr = 0; req1_data = 0;
      #12;
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", clear_done, 0);
      chk("rst_err", addr_err, 0);
      req0_valid = 1; #1;
      chk("rst_ready0", req0_ready, 0);
      req0_valid = 0;
      tick; rst_n = 1;
      tick;
      chk("post_rst_wr_en", wr_en, 0);

      // single requester
      req0_valid = 1; req0_addr = 5; req0_data = 8'h3C; #1;
      chk("single_ready0", req0_ready, 1);
      chk("single_ready1", req1_ready, 0);
      tick; req0_valid = 0;
      chk("single_wr_en", wr_en, 1);
      chk("single_addr", wr_addr, 5);
      chk("single_data", wr_data, 8'h3C);
      tick;
      chk("idle_wr_en", wr_en, 0);
      chk("idle_hold_addr", wr_addr, 5);

      // req1 alone, leaving req1 as last grant
      req1_valid = 1; req1_addr = 9; req1_data = 8'h11;
      tick; req1_valid = 0;
      chk("r1_addr", wr_addr, 9);
      chk("r1_data", wr_data, 8'h11);

      // contention
      req0_addr = 0; req1_addr = 100;
      for (int i = 0; i < 4; i++) begin
         req0_valid = 1; req1_valid = 1;
         req0_data = 8'hA0; req1_data = 8'hB0; #1;
         chk("cont_gnt0", req0_ready, eg[i]);
         chk("cont_gnt1", req1_ready, !eg[i]);
         tick;
         chk("cont_addr", wr_addr, ea[i]);
         chk("cont_data", wr_data, eg[i] ? 8'hA0 : 8'hB0);
         if (eg[i]) req0_addr++;
         else       req1_addr++;
      end
      req0_valid = 0; req1_valid = 0;

      // out-of-range address
      req0_valid = 1; req0_addr = 800; req0_data = 8'h77; #1;
      chk("oor_ready", req0_ready, 1);
      tick; req0_valid = 0;
      chk("oor_wr_en", wr_en, 0);
      chk("oor_err", addr_err, 1);
      chk("oor_hold", wr_addr, 101);
      tick;
      chk("oor_err_once", addr_err, 0);

      // full clear with stalled req1
      clear_req = 1; tick; clear_req = 0;
      chk("pend_no_start", busy, 0);
      frame_start = 1; clear_color = 8'h07;
      tick; frame_start = 0; clear_color = 8'h00;
      req1_valid = 1; req1_addr = 50; req1_data = 8'h55; #1;
      chk("clr_busy0", busy, 1);
      chk("clr_stall", req1_ready, 0);
      bad = 0; bc = 0; dc = 0; rc = 0;
      for (int k = 0; k < 768; k++) begin
         tick;
         if (!(wr_en === 1'b1 && wr_addr === 10'(k) &&
               wr_data === 8'h07)) bad++;
         if (busy) bc++;
         if (clear_done) dc++;
         if (req1_ready) rc++;
      end
      chk("clr_writes_bad", bad, 0);
      chk("clr_busy_cnt", bc, 767);
      chk("clr_done_cnt", dc, 1);
      chk("clr_done_last", clear_done, 1);
      chk("clr_ready_cnt", rc, 1);
      chk("clr_ready_after", req1_ready, 1);
      tick; req1_valid = 0;
      chk("post_clr_wr_en", wr_en, 1);
      chk("post_clr_addr", wr_addr, 50);
      chk("post_clr_data", wr_data, 8'h55);
      chk("post_clr_done", clear_done, 0);
      chk("post_clr_busy", busy, 0);

      // clear_req coincident with frame_start, then restart at 400
      clear_req = 1; frame_start = 1; clear_color = 8'h2A;
      tick; clear_req = 0; frame_start = 0;
      chk("coinc_busy", busy, 1);
      for (int k = 0; k < 400; k++) tick;
      chk("pre_restart_addr", wr_addr, 399);
      chk("pre_restart_data", wr_data, 8'h2A);
      frame_start = 1; clear_color = 8'h15;
      tick; frame_start = 0;
      chk("restart_busy", busy, 1);
      tick;
      chk("restart_addr0", wr_addr, 0);
      chk("restart_data0", wr_data, 8'h15);
      chk("restart_wr_en", wr_en, 1);
      tick;
      chk("restart_addr1", wr_addr, 1);

      // pending set mid-clear, then reset abandons both
      clear_req = 1; tick; clear_req = 0;
      tick;
      rst_n = 0; #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_wr_en", wr_en, 0);
      chk("mid_rst_addr", wr_addr, 0);
      chk("mid_rst_data", wr_data, 0);
      tick; rst_n = 1;
      frame_start = 1; tick; frame_start = 0;
      chk("rst_drops_pend", busy, 0);
      chk("rst_no_wr", wr_en, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
